// File: rtl/interrupt_ack_controller_if.sv
// Host IACK bus and interrupt-controller bundle for
// interrupt_ack_controller.
interface interrupt_ack_controller_if;
    logic       host_as_n;
    logic [2:0] host_fc;
    logic [3:0] host_address_hi;
    logic [2:0] host_address_lo;
    logic [7:0] intc_vector;
    logic [2:0] intc_priority;
    logic       intc_priority_gs;
    logic       host_dtack_n;
    logic       host_vpa_n;
    logic [7:0] vector_qout;
    logic       vector_oe;
    logic [7:0] ack_clear;
    logic [7:0] spurious_count;
    logic       busy;

    modport master (
        output host_as_n, host_fc, host_address_hi, host_address_lo,
        output intc_vector, intc_priority, intc_priority_gs,
        input  host_dtack_n, host_vpa_n, vector_qout, vector_oe,
        input  ack_clear, spurious_count, busy
    );

    modport slave (
        input  host_as_n, host_fc, host_address_hi, host_address_lo,
        input  intc_vector, intc_priority, intc_priority_gs,
        output host_dtack_n, host_vpa_n, vector_qout, vector_oe,
        output ack_clear, spurious_count, busy
    );
endinterface

// File: rtl/interrupt_ack_controller.sv
// 68000 interrupt-acknowledge responder: vectored/autovector answer,
// pending-clear pulse and saturating spurious-acknowledge counter.
module interrupt_ack_controller #(
    parameter logic [7:0] AUTOVECTOR_MASK = 8'b0000_1000,
    parameter logic [7:0] SPURIOUS_VECTOR = 8'h18
) (
    input logic clock,
    input logic reset,
    interrupt_ack_controller_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, DECODE, ACK, HOLD, IGNORE
    } state_t;

    state_t state, state_next;

    logic       as_meta, as_sync;
    logic       iack;
    logic [2:0] lvl_c;
    logic       valid_c, auto_c;

    logic       dtack_n_q, vpa_n_q, oe_q, busy_q;
    logic [7:0] qout_q, clear_q, count_q;
    logic       dtack_n_d, vpa_n_d, oe_d, busy_d;
    logic [7:0] qout_d, clear_d, count_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            as_meta <= 1'b1;
            as_sync <= 1'b1;
        end else begin
            as_meta <= bus.host_as_n;
            as_sync <= as_meta;
        end
    end

    assign iack = !as_sync && bus.host_fc == 3'b111
               && bus.host_address_hi == 4'hF;
    assign lvl_c = bus.host_address_lo;
    assign valid_c = bus.intc_priority_gs
                  && bus.intc_priority == lvl_c
                  && lvl_c != 3'd0;
    assign auto_c = valid_c && AUTOVECTOR_MASK[lvl_c];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (iack)          state_next = DECODE;
                else if (!as_sync) state_next = IGNORE;
            end
            DECODE: state_next = ACK;
            ACK:    state_next = HOLD;
            HOLD:   if (as_sync) state_next = IDLE;
            IGNORE: if (as_sync) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Response is computed while in DECODE so it lands on the ACK edge.
    always_comb begin
        dtack_n_d = dtack_n_q;
        vpa_n_d   = vpa_n_q;
        oe_d      = oe_q;
        qout_d    = qout_q;
        clear_d   = 8'h00;
        count_d   = count_q;
        busy_d    = state_next != IDLE;
        unique case (state)
            DECODE: begin
                dtack_n_d = auto_c;
                vpa_n_d   = !auto_c;
                oe_d      = !auto_c;
                if (!auto_c)
                    qout_d = valid_c ? {bus.intc_vector[7:3], lvl_c}
                                     : SPURIOUS_VECTOR;
                if (valid_c)
                    clear_d = 8'd1 << lvl_c;
                else if (count_q != 8'hFF)
                    count_d = count_q + 8'd1;
            end
            HOLD: begin
                if (as_sync) begin
                    dtack_n_d = 1'b1;
                    vpa_n_d   = 1'b1;
                    oe_d      = 1'b0;
                end
            end
            IDLE, IGNORE: begin
                dtack_n_d = 1'b1;
                vpa_n_d   = 1'b1;
                oe_d      = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dtack_n_q <= 1'b1;
            vpa_n_q   <= 1'b1;
            oe_q      <= 1'b0;
            qout_q    <= 8'h00;
            clear_q   <= 8'h00;
            count_q   <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            dtack_n_q <= dtack_n_d;
            vpa_n_q   <= vpa_n_d;
            oe_q      <= oe_d;
            qout_q    <= qout_d;
            clear_q   <= clear_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.host_dtack_n   = dtack_n_q;
    assign bus.host_vpa_n     = vpa_n_q;
    assign bus.vector_oe      = oe_q;
    assign bus.vector_qout    = qout_q;
    assign bus.ack_clear      = clear_q;
    assign bus.spurious_count = count_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_interrupt_ack_controller.sv
// Scoreboard bench for interrupt_ack_controller: driver queues expected
// responses from a reference model, monitor pops them on each response.
module tb_interrupt_ack_controller;
    localparam logic [7:0] MASK = 8'b0000_1000;
    localparam logic [7:0] SPUR = 8'h18;

    logic clock = 1'b0;
    logic reset;

    interrupt_ack_controller_if bus();

    interrupt_ack_controller #(
        .AUTOVECTOR_MASK(MASK),
        .SPURIOUS_VECTOR(SPUR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         autov;
        logic [7:0] vec;
        logic [7:0] clr;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Reference: an acknowledge is genuine only for the live nonzero level.
    function automatic exp_t model(input int lvl, input int prio,
                                   input bit gs, input logic [7:0] base);
        exp_t e;
        bit valid;
        valid   = gs && prio == lvl && lvl != 0;
        e.autov = valid && MASK[lvl];
        e.vec   = valid ? 8'((int'(base) / 8) * 8 + lvl) : SPUR;
        e.clr   = valid ? 8'(1 << lvl) : 8'h00;
        if (!valid && model_cnt < 255) model_cnt++;
        e.cnt   = 8'(model_cnt);
        return e;
    endfunction

    bit prev_resp = 1'b0;
    bit clr_chk = 1'b0;

    always @(posedge clock) begin
        bit resp;
        exp_t e;
        #1;
        if (clr_chk) begin
            chk("ack_clear_width", 32'(bus.ack_clear), 32'h0);
            clr_chk = 1'b0;
        end
        if (reset) begin
            prev_resp = 1'b0;
        end else begin
            resp = !bus.host_dtack_n || !bus.host_vpa_n;
            if (resp && !prev_resp) begin
                chk("resp_expected", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("dtack_n", 32'(bus.host_dtack_n), 32'(e.autov));
                    chk("vpa_n", 32'(bus.host_vpa_n), 32'(!e.autov));
                    chk("vector_oe", 32'(bus.vector_oe), 32'(!e.autov));
                    if (!e.autov)
                        chk("vector_qout", 32'(bus.vector_qout), 32'(e.vec));
                    chk("ack_clear", 32'(bus.ack_clear), 32'(e.clr));
                    chk("spurious_count", 32'(bus.spurious_count),
                        32'(e.cnt));
                    if (e.clr != 8'h00) clr_chk = 1'b1;
                end
            end
            prev_resp = resp;
        end
    end

    task automatic bus_cycle(input int lvl, input int prio, input bit gs,
                             input logic [7:0] base, input logic [2:0] fc,
                             input logic [3:0] hi, input int new_prio,
                             input bit rst_in_hold);
        bit   is_iack;
        bit   got;
        int   n;
        exp_t e;
        is_iack = fc == 3'b111 && hi == 4'hF;
        @(negedge clock);
        bus.host_fc          = fc;
        bus.host_address_hi  = hi;
        bus.host_address_lo  = 3'(lvl);
        bus.intc_vector      = base;
        bus.intc_priority    = 3'(prio);
        bus.intc_priority_gs = gs;
        if (is_iack) begin
            e = model(lvl, prio, gs, base);
            exp_q.push_back(e);
        end
        bus.host_as_n = 1'b0;
        n = 0;
        got = 1'b0;
        while (n < 12 && !got) begin
            @(posedge clock);
            #1;
            n++;
            got = !bus.host_dtack_n || !bus.host_vpa_n;
        end
        if (new_prio >= 0) bus.intc_priority = 3'(new_prio);
        if (is_iack) begin
            chk("ack_latency", 32'(n), 32'd4);
            if (!got) exp_q.delete();
        end else begin
            chk("ignore_no_resp", 32'(got), 32'h0);
            chk("ignore_busy", 32'(bus.busy), 32'h1);
        end
        repeat (2) @(posedge clock);
        #1;
        if (is_iack && got && !e.autov)
            chk("hold_vector", 32'(bus.vector_qout), 32'(e.vec));
        if (is_iack && got)
            chk("hold_ack_clear", 32'(bus.ack_clear), 32'h0);
        if (rst_in_hold) begin
            #2 reset = 1'b1;
            #1;
            chk("rst_dtack_n", 32'(bus.host_dtack_n), 32'h1);
            chk("rst_vpa_n", 32'(bus.host_vpa_n), 32'h1);
            chk("rst_oe", 32'(bus.vector_oe), 32'h0);
            chk("rst_busy", 32'(bus.busy), 32'h0);
            chk("rst_ack_clear", 32'(bus.ack_clear), 32'h0);
            model_cnt = 0;
            @(negedge clock);
            bus.host_as_n = 1'b1;
            @(negedge clock);
            reset = 1'b0;
        end else begin
            @(negedge clock);
            bus.host_as_n = 1'b1;
            n = 0;
            do begin
                @(posedge clock);
                #1;
                n++;
            end while (bus.busy && n < 12);
            chk("release_latency", 32'(n), 32'd3);
            chk("release_dtack_n", 32'(bus.host_dtack_n), 32'h1);
            chk("release_vpa_n", 32'(bus.host_vpa_n), 32'h1);
            chk("release_oe", 32'(bus.vector_oe), 32'h0);
        end
        repeat (2) @(posedge clock);
    endtask

    initial begin
        reset = 1'b1;
        bus.host_as_n = 1'b1;
        bus.host_fc = 3'b000;
        bus.host_address_hi = 4'h0;
        bus.host_address_lo = 3'd0;
        bus.intc_vector = 8'h00;
        bus.intc_priority = 3'd0;
        bus.intc_priority_gs = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_dtack_n", 32'(bus.host_dtack_n), 32'h1);
        chk("reset_vpa_n", 32'(bus.host_vpa_n), 32'h1);
        chk("reset_oe", 32'(bus.vector_oe), 32'h0);
        chk("reset_qout", 32'(bus.vector_qout), 32'h0);
        chk("reset_ack_clear", 32'(bus.ack_clear), 32'h0);
        chk("reset_count", 32'(bus.spurious_count), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        bus_cycle(5, 5, 1'b1, 8'h40, 3'b111, 4'hF, -1, 1'b0);
        bus_cycle(3, 3, 1'b1, 8'h40, 3'b111, 4'hF, -1, 1'b0);
        bus_cycle(6, 7, 1'b1, 8'h40, 3'b111, 4'hF, -1, 1'b0);
        bus_cycle(0, 0, 1'b1, 8'h40, 3'b111, 4'hF, -1, 1'b0);
        bus_cycle(4, 4, 1'b0, 8'h40, 3'b111, 4'hF, -1, 1'b0);
        bus_cycle(5, 5, 1'b1, 8'h40, 3'b101, 4'hF, -1, 1'b0);
        bus_cycle(5, 5, 1'b1, 8'h40, 3'b111, 4'hF, -1, 1'b0);
        bus_cycle(5, 5, 1'b1, 8'hA8, 3'b111, 4'hF, 7, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int lvl, prio;
            bit gs;
            logic [2:0] fc;
            logic [3:0] hi;
            lvl  = $urandom_range(0, 7);
            gs   = $urandom_range(0, 3) != 0;
            prio = $urandom_range(0, 1) != 0 ? lvl : $urandom_range(0, 7);
            fc   = $urandom_range(0, 5) == 0 ? 3'($urandom_range(0, 7))
                                             : 3'b111;
            hi   = $urandom_range(0, 5) == 0 ? 4'($urandom_range(0, 15))
                                             : 4'hF;
            bus_cycle(lvl, prio, gs, 8'($urandom), fc, hi, -1, 1'b0);
        end

        for (int i = 0; i < 260; i++)
            bus_cycle(6, 7, 1'b1, 8'h40, 3'b111, 4'hF, -1, 1'b0);
        chk("count_saturated", 32'(bus.spurious_count), 32'hFF);

        bus_cycle(5, 5, 1'b1, 8'h40, 3'b111, 4'hF, -1, 1'b1);
        chk("count_after_reset", 32'(bus.spurious_count), 32'h0);
        bus_cycle(5, 5, 1'b1, 8'h40, 3'b111, 4'hF, -1, 1'b0);
        bus_cycle(2, 1, 1'b1, 8'h60, 3'b111, 4'hF, -1, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
